// File: rtl/collective_pkg.sv
// Shared flit field layout for the packeter, the reduction table and the injection queue.
// The children count is prepended above the packeted flit to form one queue entry.
package collective_pkg;

    localparam int unsigned FlitWidth    = 82;
    localparam int unsigned ValidBitPos  = 81;

    localparam int unsigned PayloadPos   = 0;
    localparam int unsigned PayloadWidth = 32;
    localparam int unsigned OpPos        = 32;
    localparam int unsigned OpWidth      = 4;
    localparam int unsigned AlgTypePos   = 36;
    localparam int unsigned AlgTypeWidth = 3;
    localparam int unsigned TagPos       = 39;
    localparam int unsigned TagWidth     = 8;
    localparam int unsigned ContextIdPos   = 47;
    localparam int unsigned ContextIdWidth = 8;
    localparam int unsigned RankPos      = 55;
    localparam int unsigned RankWidth    = 8;
    localparam int unsigned CoordWidth   = 3;
    localparam int unsigned SrcXPos      = 63;
    localparam int unsigned SrcYPos      = 66;
    localparam int unsigned SrcZPos      = 69;
    localparam int unsigned DstXPos      = 72;
    localparam int unsigned DstYPos      = 75;
    localparam int unsigned DstZPos      = 78;

    localparam int unsigned ChildPos     = 82;
    localparam int unsigned ChildWidth   = 3;
    localparam int unsigned EntryWidth   = FlitWidth + ChildWidth;

    typedef struct packed {
        logic [ChildWidth-1:0] children;
        logic [FlitWidth-1:0]  flit;
    } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered pointers and fill count; head entry is visible combinationally.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 85,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [Width-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [Width-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);
    localparam logic [PtrW:0] CntOne  = (PtrW+1)'(1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CntFull);
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CntOne;
                2'b01:   count <= count - CntOne;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/flit_inject_queue.sv
// Injection stage: tags packeted flits with a children count, queues them and issues
// them to the router injection port under credit flow control, discarding invalid flits.
module flit_inject_queue
    import collective_pkg::*;
#(
    parameter int unsigned Depth   = 8,
    parameter int unsigned Credits = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FlitWidth-1:0]    in_flit,
    input  logic [ChildWidth-1:0]   in_children,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [EntryWidth-1:0]   out_entry,
    output logic                    out_valid,
    input  logic                    credit_in,
    output logic [$clog2(Depth):0]  occupancy,
    output logic [15:0]             drop_count,
    output logic                    credit_err
);

    localparam int unsigned CredW = $clog2(Credits + 1);
    localparam logic [CredW-1:0] CredMax = CredW'(Credits);

    logic                  handshake;
    logic                  push;
    logic                  drop;
    logic                  issue;
    logic                  fifo_full;
    logic                  fifo_empty;
    entry_t                wr_entry;
    logic [EntryWidth-1:0] head_entry;
    logic [CredW-1:0]      credit_cnt;

    assign in_ready  = ~fifo_full;
    assign handshake = in_valid & in_ready;
    assign push      = handshake & in_flit[ValidBitPos];
    assign drop      = handshake & ~in_flit[ValidBitPos];
    assign issue     = ~fifo_empty & (credit_cnt != '0);

    assign wr_entry.children = in_children;
    assign wr_entry.flit     = in_flit;

    sync_fifo #(
        .Width (EntryWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (issue),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_entry <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= issue;
            if (issue) out_entry <= head_entry;
        end
    end

    // A return at full credit with no concurrent issue is a protocol error: hold and flag it.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CredMax;
            credit_err <= 1'b0;
        end else begin
            case ({issue, credit_in})
                2'b10:   credit_cnt <= credit_cnt - CredW'(1);
                2'b01: begin
                    if (credit_cnt == CredMax) credit_err <= 1'b1;
                    else                       credit_cnt <= credit_cnt + CredW'(1);
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       drop_count <= '0;
        else if (drop) drop_count <= drop_count + 16'd1;
    end

endmodule

// File: tb/tb_flit_inject_queue.sv
// Bench for flit_inject_queue: a queue-level reference model predicts issued entries into a
// scoreboard that an independent negedge monitor drains whenever the DUT strobes out_valid.
module tb_flit_inject_queue;
    import collective_pkg::*;

    localparam int Depth   = 8;
    localparam int Credits = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [FlitWidth-1:0]   in_flit;
    logic [ChildWidth-1:0]  in_children;
    logic                   in_valid;
    logic                   in_ready;
    logic [EntryWidth-1:0]  out_entry;
    logic                   out_valid;
    logic                   credit_in;
    logic [$clog2(Depth):0] occupancy;
    logic [15:0]            drop_count;
    logic                   credit_err;

    always #5 clk = ~clk;

    flit_inject_queue #(
        .Depth   (Depth),
        .Credits (Credits)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_children (in_children),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_entry   (out_entry),
        .out_valid   (out_valid),
        .credit_in   (credit_in),
        .occupancy   (occupancy),
        .drop_count  (drop_count),
        .credit_err  (credit_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stored entries, issued-but-unchecked entries, credits, counters.
    logic [EntryWidth-1:0] mq[$];
    logic [EntryWidth-1:0] exp_q[$];
    int                    cred;
    int                    drops;
    bit                    err;
    logic [EntryWidth-1:0] last_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FlitWidth-1:0] mk(input bit vb, input logic [31:0] payload);
        logic [95:0]          r;
        logic [FlitWidth-1:0] f;
        r = {$urandom(), $urandom(), $urandom()};
        f = r[FlitWidth-1:0];
        f[31:0] = payload;
        f[ValidBitPos] = vb;
        return f;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; credit_in = 1'b0;
        in_flit = '0; in_children = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); exp_q.delete();
        cred = Credits; drops = 0; err = 1'b0; last_out = '0;
        check("rst_occupancy", occupancy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_entry", out_entry, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    // One clock: drive inputs, predict the edge from the model, then compare registered outputs.
    task automatic step(input bit v, input logic [FlitWidth-1:0] f, input logic [ChildWidth-1:0] ch,
                        input bit cr);
        bit iss, acc;
        in_valid = v; in_flit = f; in_children = ch; credit_in = cr;
        #1;
        check("in_ready", in_ready, mq.size() != Depth);
        iss = (mq.size() > 0) && (cred > 0);
        acc = v && (mq.size() != Depth);
        @(posedge clk); #1;
        if (iss) begin
            last_out = mq.pop_front();
            exp_q.push_back(last_out);
        end
        if (acc && f[ValidBitPos]) mq.push_back({ch, f});
        else if (acc)              drops = (drops + 1) % 65536;
        if (iss && !cr)            cred--;
        else if (!iss && cr) begin
            if (cred == Credits) err = 1'b1;
            else                 cred++;
        end
        in_valid = 1'b0; credit_in = 1'b0;
        check("occupancy", occupancy, mq.size());
        check("out_valid", out_valid, iss);
        check("out_entry_hold", out_entry, last_out);
        check("drop_count", drop_count, drops);
        check("credit_err", credit_err, err);
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, cr);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_issue: got %0h expected no issue (t=%0t)", out_entry, $time);
            end else begin
                check("issue_entry", out_entry, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Single flit: children=2, payload DEADBEEF, issued on the second edge.
        do_reset();
        step(1'b1, mk(1'b1, 32'hDEADBEEF), 3'd2, 1'b0);
        check("latency_not_yet", out_valid, 0);
        step(1'b0, '0, '0, 1'b0);
        check("latency_issue", out_valid, 1);
        check("single_children", out_entry[84:82], 3'd2);
        check("single_payload", out_entry[31:0], 32'hDEADBEEF);
        idle(2, 1'b0);

        // Burst of 10 with no credits: 4 issue, 6 wait, then 6 credits drain them.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, mk(1'b1, 32'h100 + i), 3'(i), 1'b0);
        check("burst_occupancy", occupancy, 6);
        idle(3, 1'b0);
        idle(6, 1'b1);
        idle(3, 1'b0);
        check("burst_drained", occupancy, 0);

        // Fill to full with zero credits; extra offers ignored; one credit frees one slot.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, mk(1'b1, 32'h200 + i), 3'(i), 1'b0);
        check("full_in_ready", in_ready, 0);
        step(1'b1, mk(1'b1, 32'h2FF), 3'd7, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        check("full_freed_ready", in_ready, 1);
        idle(8, 1'b1);
        idle(2, 1'b0);

        // Invalid flits interleaved among valid ones.
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, mk(!(i == 1 || i == 4 || i == 6), 32'h300 + i), 3'(i), 1'b0);
        idle(2, 1'b1);
        check("drop_total", drop_count, 3);
        idle(4, 1'b1);

        // Credit overflow at idle, then a concurrent issue+return.
        do_reset();
        step(1'b0, '0, '0, 1'b1);
        check("overflow_err", credit_err, 1);
        step(1'b1, mk(1'b1, 32'h400), 3'd1, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, mk(1'b1, 32'h410 + i), 3'(i), 1'b0);
        idle(4, 1'b0);
        idle(6, 1'b1);

        // Reset mid-burst with 5 entries queued: nothing stale may issue afterwards.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, mk(1'b1, 32'h500 + i), 3'(i), 1'b0);
        check("pre_flush_occupancy", occupancy, 5);
        do_reset();
        idle(6, 1'b0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, mk($urandom_range(0, 4) != 0, $urandom()),
                 3'($urandom()), (exp_q.size() == 0) && ($urandom_range(0, 2) == 0));
        for (int i = 0; i < 40 && mq.size() > 0; i++) step(1'b0, '0, '0, 1'b1);
        @(negedge clk); #1;
        check("final_model_empty", mq.size(), 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
